// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the execute-stage ALU and the multi-cycle
// multiply/divide sequencer.
//   alu_op_e        : opcode set of the single-cycle ALU
//   muldiv_op_e     : RV32M operation select (funct3 order)
//   muldiv_state_e  : sequencer state encoding
package muldiv_seq_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned MULDIV_ITERS = 32;
  localparam int unsigned CNT_W        = $clog2(MULDIV_ITERS);
  localparam logic [31:0] DIV_OVF_A    = 32'h8000_0000;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response handshake bundle between the execute stage and the
// multiply/divide sequencer.
//   master : issues req_*, accepts rsp_* (execute stage)
//   slave  : the sequencer
interface muldiv_seq_if
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
);

  logic            req_valid;
  logic            req_ready;
  muldiv_op_e      req_op;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            busy;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, busy
  );

endinterface

// File: rtl/alu.sv
// Single-cycle execute-stage ALU (combinational).
//   op        : alu_op_e operation select
//   operand_a : first operand
//   operand_b : second operand (shift amount in [4:0] for shifts)
//   result_c  : combinational result
module alu
  import muldiv_seq_pkg::*;
(
  input  alu_op_e     op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic [31:0] result_c
);

  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD:  result_c = operand_a + operand_b;
      ALU_SUB:  result_c = operand_a - operand_b;
      ALU_AND:  result_c = operand_a & operand_b;
      ALU_OR:   result_c = operand_a | operand_b;
      ALU_XOR:  result_c = operand_a ^ operand_b;
      ALU_SLT:  result_c = 32'($signed(operand_a) < $signed(operand_b));
      ALU_SLTU: result_c = 32'(operand_a < operand_b);
      ALU_SLL:  result_c = operand_a << operand_b[4:0];
      ALU_SRL:  result_c = operand_a >> operand_b[4:0];
      ALU_SRA:  result_c = 32'($signed(operand_a) >>> operand_b[4:0]);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer. Runs a 32-step shift-add
// multiply or restoring divide on operand magnitudes, then restores the sign
// in one FIXUP cycle through the shared ALU.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : muldiv_seq_if slave (req_* in, req_ready/rsp_*/busy out)
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned XLEN           = 32,
  parameter bit          SPECIAL_BYPASS = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  if (XLEN != 32) begin : g_xlen_check
    $error("muldiv_seq: only XLEN=32 is supported");
  end

  muldiv_state_e   state;
  muldiv_op_e      op_q;
  logic            sa;
  logic            sb;
  logic            b_zero;
  logic [XLEN-1:0] mb;
  logic [XLEN-1:0] hi;     // multiply high word / divide partial remainder
  logic [XLEN-1:0] lo;     // multiply low word / divide quotient
  logic [CNT_W-1:0] cnt;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            busy_q;

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.busy       = busy_q;

  // Request decode: operand signs, magnitudes and special divide cases.
  logic            sa_c;
  logic            sb_c;
  logic [XLEN-1:0] abs_a_c;
  logic [XLEN-1:0] abs_b_c;
  logic            is_div_c;
  logic            ovf_c;
  logic            special_c;
  logic [XLEN-1:0] special_res_c;

  always_comb begin
    sa_c          = (bus.req_op inside {MULH, MULHSU, DIV, REM}) && bus.req_a[XLEN-1];
    sb_c          = (bus.req_op inside {MULH, DIV, REM}) && bus.req_b[XLEN-1];
    abs_a_c       = sa_c ? -bus.req_a : bus.req_a;
    abs_b_c       = sb_c ? -bus.req_b : bus.req_b;
    is_div_c      = bus.req_op inside {DIV, DIVU, REM, REMU};
    ovf_c         = (bus.req_op inside {DIV, REM}) && (bus.req_a == DIV_OVF_A) && (bus.req_b == '1);
    special_c     = is_div_c && ((bus.req_b == '0) || ovf_c);
    special_res_c = '0;
    if (bus.req_b == '0) begin
      special_res_c = (bus.req_op inside {DIV, DIVU}) ? '1 : bus.req_a;
    end else if (ovf_c) begin
      special_res_c = (bus.req_op == DIV) ? DIV_OVF_A : '0;
    end
  end

  // 33-bit iteration datapath: multiply add-with-carry, divide trial subtract.
  logic [XLEN:0]   add_c;
  logic [XLEN:0]   rs_c;
  logic [XLEN-1:0] sub_c;
  logic            ge_c;

  always_comb begin
    add_c = {1'b0, hi} + {1'b0, (lo[0] ? mb : '0)};
    rs_c  = {hi, lo[XLEN-1]};
    ge_c  = rs_c >= {1'b0, mb};
    sub_c = XLEN'(rs_c - {1'b0, mb});
  end

  // Sign fix-up: pick the result word and whether it needs negating.
  // For MULH* the 64-bit negation's high word is ~hi + (lo==0), which equals
  // 0 - (hi + (lo!=0)); that lets one 32-bit ALU subtract do the job.
  logic [XLEN-1:0] fix_word_c;
  logic [XLEN-1:0] alu_b_c;
  logic            fix_neg_c;
  logic [XLEN-1:0] alu_res_c;
  logic [XLEN-1:0] fix_res_c;

  always_comb begin
    fix_word_c = lo;
    alu_b_c    = lo;
    fix_neg_c  = 1'b0;
    case (op_q)
      MULH, MULHSU, MULHU: begin
        fix_word_c = hi;
        alu_b_c    = hi + XLEN'(lo != '0);
        fix_neg_c  = sa ^ sb;
      end
      DIV, DIVU: begin
        fix_neg_c  = (sa ^ sb) && !b_zero;
      end
      REM, REMU: begin
        fix_word_c = hi;
        alu_b_c    = hi;
        fix_neg_c  = sa;
      end
      default: ;
    endcase
    fix_res_c = fix_neg_c ? alu_res_c : fix_word_c;
  end

  alu u_alu (
    .op        (ALU_SUB),
    .operand_a (32'h0),
    .operand_b (alu_b_c),
    .result_c  (alu_res_c)
  );

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= MUL;
      sa           <= 1'b0;
      sb           <= 1'b0;
      b_zero       <= 1'b0;
      mb           <= '0;
      hi           <= '0;
      lo           <= '0;
      cnt          <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            op_q        <= bus.req_op;
            sa          <= sa_c;
            sb          <= sb_c;
            b_zero      <= (bus.req_b == '0);
            mb          <= abs_b_c;
            lo          <= abs_a_c;
            hi          <= '0;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (SPECIAL_BYPASS && special_c) begin
              rsp_result_q <= special_res_c;
              rsp_valid_q  <= 1'b1;
              state        <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_q inside {DIV, DIVU, REM, REMU}) begin
            hi <= ge_c ? sub_c : rs_c[XLEN-1:0];
            lo <= {lo[XLEN-2:0], ge_c};
          end else begin
            hi <= add_c[XLEN:1];
            lo <= {add_c[0], lo[XLEN-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MULDIV_ITERS - 1)) begin
            state <= FIXUP;
          end
        end
        FIXUP: begin
          rsp_result_q <= fix_res_c;
          rsp_valid_q  <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: one instance with the special-case bypass
// and one without, steered by sel. Expected responses are queued on each
// request handshake and popped by an independent response monitor.
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        sel;
  logic        req_valid;
  logic        rsp_ready;
  muldiv_op_e  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;

  muldiv_seq_if #(.XLEN(32)) bus_b ();
  muldiv_seq_if #(.XLEN(32)) bus_n ();

  assign bus_b.req_valid = req_valid & sel;
  assign bus_b.req_op    = req_op;
  assign bus_b.req_a     = req_a;
  assign bus_b.req_b     = req_b;
  assign bus_b.rsp_ready = rsp_ready;
  assign bus_n.req_valid = req_valid & ~sel;
  assign bus_n.req_op    = req_op;
  assign bus_n.req_a     = req_a;
  assign bus_n.req_b     = req_b;
  assign bus_n.rsp_ready = rsp_ready;

  muldiv_seq #(.XLEN(32), .SPECIAL_BYPASS(1'b1)) u_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  muldiv_seq #(.XLEN(32), .SPECIAL_BYPASS(1'b0)) u_nob (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_n.slave)
  );

  logic        m_req_ready;
  logic        m_rsp_valid;
  logic [31:0] m_rsp_result;
  logic        m_busy;
  assign m_req_ready  = sel ? bus_b.req_ready  : bus_n.req_ready;
  assign m_rsp_valid  = sel ? bus_b.rsp_valid  : bus_n.rsp_valid;
  assign m_rsp_result = sel ? bus_b.rsp_result : bus_n.rsp_result;
  assign m_busy       = sel ? bus_b.busy       : bus_n.busy;

  typedef struct {
    logic [31:0] res;
    int unsigned hs;
    int unsigned lat;
  } exp_t;

  typedef struct {
    muldiv_op_e  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errs++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Architectural RV32M result computed with wide integer arithmetic.
  function automatic logic [31:0] ref_model(input muldiv_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa64;
    longint          sb64;
    longint unsigned ua64;
    longint unsigned ub64;
    logic [63:0]     p;
    int              si_a;
    int              si_b;
    sa64 = longint'($signed(a));
    sb64 = longint'($signed(b));
    ua64 = {32'h0, a};
    ub64 = {32'h0, b};
    si_a = $signed(a);
    si_b = $signed(b);
    case (op)
      MUL:    begin p = ua64 * ub64;          return p[31:0];  end
      MULH:   begin p = sa64 * sb64;          return p[63:32]; end
      MULHSU: begin p = sa64 * longint'(ub64); return p[63:32]; end
      MULHU:  begin p = ua64 * ub64;          return p[63:32]; end
      DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(si_a / si_b);
      end
      REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(si_a % si_b);
      end
      DIVU: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input muldiv_op_e op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (!(op inside {DIV, DIVU, REM, REMU})) return 1'b0;
    if (b == 32'h0) return 1'b1;
    return (op inside {DIV, REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Response monitor: pops on the first valid cycle, checks latency and value,
  // then checks that the response holds while stalled.
  logic        seen = 1'b0;
  logic [31:0] held = 32'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      seen = 1'b0;
    end else if (m_rsp_valid) begin
      check("req_ready_in_done", 32'(m_req_ready), 32'h0);
      if (!seen) begin
        seen = 1'b1;
        held = m_rsp_result;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL unexpected_rsp: got %h required no response", m_rsp_result);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", m_rsp_result, mon_e.res);
          check("latency", 32'(cyc - mon_e.hs + 1), 32'(mon_e.lat));
        end
      end else begin
        check("rsp_hold", m_rsp_result, held);
      end
      if (rsp_ready) seen = 1'b0;
    end
  end

  task automatic issue(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    exp_t        e;
    int unsigned w;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!m_req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!m_req_ready) begin
      n_checks++;
      n_errs++;
      $display("FAIL req_timeout: req_ready got 0 required 1");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res = exp;
    e.hs  = cyc;
    e.lat = (sel && is_special(op, a, b)) ? 1 : 34;
    exp_q.push_back(e);
    // Scramble request inputs once accepted; they must be ignored now.
    req_valid = 1'b0;
    req_op    = muldiv_op_e'(3'($urandom_range(0, 7)));
    req_a     = $urandom();
    req_b     = $urandom();
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while ((exp_q.size() != 0 || !m_req_ready) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (exp_q.size() != 0 || !m_req_ready) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain_timeout: pending got %0d required 0", exp_q.size());
    end
  endtask

  vec_t vecs[14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "tb_muldiv_seq watchdog");
  end

  initial begin
    muldiv_op_e  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0]  = '{MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF};
    vecs[4]  = '{DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{DIVU,   32'd100,        32'd7,         32'd14};
    vecs[7]  = '{REMU,   32'd100,        32'd7,         32'd2};
    vecs[8]  = '{DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{REM,    32'd5,          32'd0,         32'd5};
    vecs[10] = '{DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0};
    vecs[12] = '{DIV,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB};

    rst_n     = 1'b0;
    sel       = 1'b1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    req_op    = MUL;
    req_a     = 32'h0;
    req_b     = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready_b",  32'(bus_b.req_ready), 32'h1);
    check("rst_rsp_valid_b",  32'(bus_b.rsp_valid), 32'h0);
    check("rst_rsp_result_b", bus_b.rsp_result,     32'h0);
    check("rst_busy_b",       32'(bus_b.busy),      32'h0);
    check("rst_req_ready_n",  32'(bus_n.req_ready), 32'h1);
    check("rst_busy_n",       32'(bus_n.busy),      32'h0);
    rst_n = 1'b1;

    // Directed vectors back to back, first with bypass, then without.
    for (int pass = 0; pass < 2; pass++) begin
      sel = (pass == 0);
      foreach (vecs[i]) issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
      drain();
    end

    // Response stall: held stable in DONE, released, then a new request.
    sel       = 1'b1;
    rsp_ready = 1'b0;
    issue(DIVU, 32'd1000, 32'd3, 32'd333);
    for (int w = 0; w < 60 && !m_rsp_valid; w++) begin
      @(posedge clk);
      #1;
    end
    check("stall_valid", 32'(m_rsp_valid), 32'h1);
    repeat (10) @(posedge clk);
    #1;
    check("stall_busy", 32'(m_busy), 32'h1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_req_ready", 32'(m_req_ready), 32'h1);
    check("release_rsp_valid", 32'(m_rsp_valid), 32'h0);
    check("release_busy",      32'(m_busy),      32'h0);
    issue(MUL, 32'd3, 32'd5, 32'd15);
    drain();

    // Reset in the middle of a divide (cnt==15): no response may escape.
    issue(DIV, 32'd1000, 32'd7, 32'd142);
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_req_ready",  32'(m_req_ready), 32'h1);
    check("midrst_rsp_valid",  32'(m_rsp_valid), 32'h0);
    check("midrst_rsp_result", m_rsp_result,     32'h0);
    check("midrst_busy",       32'(m_busy),      32'h0);
    exp_q.delete();
    rst_n = 1'b1;
    issue(MUL, 32'd6, 32'd7, 32'd42);
    drain();

    // Randomized operations on both instances against the reference model.
    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(0, 1));
      rop = muldiv_op_e'(3'($urandom_range(0, 7)));
      ra  = pick();
      rb  = pick();
      issue(rop, ra, rb, ref_model(rop, ra, rb));
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Multi-cycle RV32M multiply/divide sequencer. It sits beside the single-cycle ALU in the execute stage and accepts one request at a time over a valid/ready handshake. It runs a 32-iteration shift-add multiply or restoring divide on operand magnitudes, applies the sign fix-up through an ALU instance, and returns the result over a second valid/ready handshake.

Parameters:
XLEN, 32, operand/result width; only 32 is supported, and elaboration must fail for any other value.
SPECIAL_BYPASS, 1, when 1 divide-by-zero and signed overflow skip the iteration phase.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  sequencer can accept (high only in IDLE)
req_op  input  3  muldiv_op_e: MUL=0 MULH=1 MULHSU=2 MULHU=3 DIV=4 DIVU=5 REM=6 REMU=7
req_a  input  XLEN  rs1 operand
req_b  input  XLEN  rs2 operand
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_result  output  XLEN  result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous: when rst_n=0 at a clock edge, state goes to IDLE, and req_ready=1, rsp_valid=0, rsp_result=0, busy=0. Reset wins over every other event, including mid-CALC and in DONE with rsp_ready=1. Any in-flight operation is discarded with no response.
- States are IDLE, CALC, FIXUP, DONE.
- IDLE, on req_valid&&req_ready:
  - Latch op, a and b.
  - Latch the sign flags: sa from MULH/MULHSU/DIV/REM; sb from MULH/DIV/REM.
  - Latch the magnitudes |a| and |b| (unsigned if that operand's flag is clear).
  - Clear the iteration counter cnt to 0.
  - Go to CALC, or to DONE when SPECIAL_BYPASS=1 and a special case applies.
- Special cases (divide ops only), with the result loaded directly:
  - b==0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - DIV/REM with a==0x80000000 and b==0xFFFFFFFF: DIV gives 0x80000000; REM gives 0.
- With SPECIAL_BYPASS=0, special cases go through CALC and FIXUP and must produce the same values.
- CALC runs exactly 32 cycles (cnt 0..31) and goes to FIXUP after the cnt==31 cycle.
- Multiply iteration:
  - 64-bit accumulator {hi,lo}, with lo initialised to |a|.
  - Each cycle, if lo[0], then hi += |b| with a 33-bit carry.
  - Then shift {carry,hi,lo} right by 1.
- Divide iteration:
  - 33-bit partial remainder r, with quotient register q initialised to |a|.
  - Each cycle: r = {r[31:0], q[31]}; q = q << 1.
  - If r >= |b|, then r -= |b| and q[0] = 1.
- FIXUP (1 cycle):
  - Negate the selected result word using the alu instance (ALU_SUB, operand_a=0), then go to DONE.
  - MUL takes lo. MULH/MULHSU/MULHU take hi of the 64-bit two's-complement negation when sa^sb.
  - DIV negates q when sa^sb. REM negates r when sa (the remainder takes the dividend's sign).
  - Unsigned ops pass through unchanged.
- DONE:
  - rsp_valid=1 and rsp_result is held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - req_ready=0 throughout DONE, so there is no back-to-back overlap.
- Latency from the request handshake edge to rsp_valid:
  - Normal operations: 34 cycles (32 CALC + 1 FIXUP + 1 to DONE).
  - Bypassed special cases: 1 cycle.
- Throughput: one operation per 35 cycles or more; the minimum is 2 for bypassed cases.
- Request inputs are ignored outside IDLE. Input changes during CALC do not affect the result.
- The result is independent of rsp_ready stall length. rsp_result is registered, with no combinational path from req_* to rsp_*.

Decomposition:
- Add to the types package: muldiv_op_e (3-bit enum above), muldiv_state_e (IDLE/CALC/FIXUP/DONE), and the constants MULDIV_ITERS=32 and DIV_OVF_A=32'h80000000.
- Reuse the existing ALU opcode constants (ALU_SUB) from the same package.
- One sub-module instance: alu (existing), used in FIXUP for negation.
- The iteration adder/subtractor stays local because it is 33 bits wide.
- No other sub-modules.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD) -> rsp_result=0xFFFFFFEB, rsp_valid 34 cycles after handshake.
- MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
- DIV a=-7, b=2 -> 0xFFFFFFFD. REM a=-7, b=2 -> 0xFFFFFFFF. DIVU a=100, b=7 -> 14. REMU -> 2.
- DIVU a=5, b=0 -> 0xFFFFFFFF after 1 cycle. REM a=5, b=0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Repeat with SPECIAL_BYPASS=0 -> same values after 34 cycles.
- Hold rsp_ready=0 for 10 cycles in DONE -> rsp_valid and rsp_result stable, req_ready=0; raise rsp_ready -> IDLE next cycle, and a new request is accepted.
- Assert rst_n=0 at cnt==15 during a DIV -> the next edge gives IDLE, rsp_valid=0, rsp_result=0, busy=0, with no response emitted. The following MUL 6*7 -> 42.
